// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Host byte link plus CPU memory debug port, seen from the loader.
//   master : the loader (consumes bytes, drives the memory port and status)
//   slave  : host / core side (drives bytes, observes memory port and status)
//   Signals: in_data/in_valid/in_ready byte handshake; mem_addr/mem_din word
//   write port; we_im/we_dm write strobes; cpu_hold core freeze; done/err status.
interface prog_loader_if #(
   parameter int ADDR_W = 10
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic              we_im;
   logic              we_dm;
   logic              cpu_hold;
   logic              done;
   logic              err;

   modport master (
      input  in_data, in_valid,
      output in_ready, mem_addr, mem_din, we_im, we_dm, cpu_hold, done, err
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, mem_addr, mem_din, we_im, we_dm, cpu_hold, done, err
   );
endinterface

// File: rtl/prog_loader.sv
// prog_loader
//   Byte-stream program/data loader in front of the CPU memory debug port.
//   Frame: CMD, LEN_LO, LEN_HI, 4*LEN payload bytes (LSB first), CSUM (XOR of
//   payload). Words are written sequentially from address 0 into instruction
//   or data memory; the core is held for the whole frame.
//   Ports: clk, rst (async, active-high), bus (prog_loader_if.master).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | wait for CMD_INST/CMD_DATA, drop any other byte
//   S_LEN0  | capture word count low byte
//   S_LEN1  | capture word count high byte; zero length skips to S_CSUM
//   S_DATA  | assemble payload bytes into mem_din, accumulate checksum
//   S_WRITE | one-cycle write strobe, byte input stalled
//   S_CSUM  | compare checksum byte, pulse done or set err, release core
module prog_loader #(
   parameter int         ADDR_W   = 10,
   parameter logic [7:0] CMD_INST = 8'hA5,
   parameter logic [7:0] CMD_DATA = 8'h5A
) (
   input logic          clk,
   input logic          rst,
   prog_loader_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM
   } state_t;

   state_t            state_q;
   logic              tgt_dm_q;
   logic [7:0]        len_lo_q;
   logic [15:0]       wcnt_q;     // words still to be written (down-counter)
   logic [1:0]        bcnt_q;
   logic [7:0]        csum_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_din_q;
   logic              in_ready_q;
   logic              we_im_q;
   logic              we_dm_q;
   logic              hold_q;
   logic              done_q;
   logic              err_q;
   logic              accept;

   assign accept = bus.in_valid & in_ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tgt_dm_q   <= 1'b0;
         len_lo_q   <= 8'h00;
         wcnt_q     <= 16'h0000;
         bcnt_q     <= 2'd0;
         csum_q     <= 8'h00;
         mem_addr_q <= '0;
         mem_din_q  <= 32'h0;
         in_ready_q <= 1'b1;
         we_im_q    <= 1'b0;
         we_dm_q    <= 1'b0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept && (bus.in_data == CMD_INST || bus.in_data == CMD_DATA)) begin
                  tgt_dm_q   <= (bus.in_data == CMD_DATA);
                  err_q      <= 1'b0;
                  hold_q     <= 1'b1;
                  mem_addr_q <= '0;
                  bcnt_q     <= 2'd0;
                  csum_q     <= 8'h00;
                  state_q    <= S_LEN0;
               end
            end
            S_LEN0: begin
               if (accept) begin
                  len_lo_q <= bus.in_data;
                  state_q  <= S_LEN1;
               end
            end
            S_LEN1: begin
               if (accept) begin
                  wcnt_q  <= {bus.in_data, len_lo_q};
                  state_q <= ({bus.in_data, len_lo_q} == 16'h0000) ? S_CSUM : S_DATA;
               end
            end
            S_DATA: begin
               if (accept) begin
                  mem_din_q[{bcnt_q, 3'b000} +: 8] <= bus.in_data;
                  csum_q <= csum_q ^ bus.in_data;
                  bcnt_q <= bcnt_q + 2'd1;
                  if (bcnt_q == 2'd3) begin
                     in_ready_q <= 1'b0;
                     we_im_q    <= ~tgt_dm_q;
                     we_dm_q    <= tgt_dm_q;
                     state_q    <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               // address advances only after the strobe cycle so it stays stable with it
               we_im_q    <= 1'b0;
               we_dm_q    <= 1'b0;
               in_ready_q <= 1'b1;
               mem_addr_q <= mem_addr_q + ADDR_W'(1);
               wcnt_q     <= wcnt_q - 16'd1;
               state_q    <= (wcnt_q == 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
               if (accept) begin
                  if (bus.in_data == csum_q) begin
                     done_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
                  hold_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign bus.we_im    = we_im_q;
   assign bus.we_dm    = we_dm_q;
   assign bus.cpu_hold = hold_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;

endmodule
